// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Adds two WIDTH-bit operands plus a
// carry-in one bit per clock through a single full-adder cell and a carry
// flip-flop, framed by a start/busy/done handshake.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - operation request, sampled only in IDLE
//   a, b  - WIDTH-bit operands, captured on an accepted start
//   cin   - carry-in, captured on an accepted start
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when sum/cout are valid
//   sum   - WIDTH-bit result, held until the next accepted start
//   cout  - final carry, held with sum
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    count;

  // Single full-adder cell working on the current LSBs.
  logic bit_s;
  logic bit_c;
  assign bit_s = op_a[0] ^ op_b[0] ^ carry;
  assign bit_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          op_a  <= {1'b0, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          carry <= bit_c;
          // Result is assembled LSB-first, so each new bit enters at the MSB.
          sum   <= {bit_s, sum[WIDTH-1:1]};
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            cout  <= bit_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
